// File: rtl/clk_meas_pkg.sv
// Shared types and default sizing for the clock period meter and its helpers.
package clk_meas_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } meas_state_t;

    localparam int W_DEFAULT       = 16;
    localparam int TIMEOUT_DEFAULT = 50000;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous level, plus a delayed copy for
// single-cycle rise/fall strobes.
module sync_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic sig_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic       sync1_reg;
    logic       sync2_reg;
    logic       prev_reg;
    logic [2:0] fill_reg;

    // fill_reg marks when prev_reg holds a genuine sample; until then the
    // reset-forced zeros must not be mistaken for a level change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            prev_reg  <= 1'b0;
            fill_reg  <= 3'b000;
        end else begin
            sync1_reg <= sig_in;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
            fill_reg  <= {fill_reg[1:0], 1'b1};
        end
    end

    assign level = sync2_reg;
    assign rise  = fill_reg[2] &  sync2_reg & ~prev_reg;
    assign fall  = fill_reg[2] & ~sync2_reg &  prev_reg;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow asynchronous square wave in clk
// cycles, with a stall timeout when no edge arrives for TIMEOUT cycles.
module clk_period_meter
    import clk_meas_pkg::*;
#(
    parameter int W       = W_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sig_in,
    output logic [W-1:0] period,
    output logic [W-1:0] high_time,
    output logic         valid,
    output logic         timeout
);

    generate
        if (TIMEOUT < 2 || TIMEOUT > (2 ** W) - 1) begin : g_bad_timeout
            $error("clk_period_meter: TIMEOUT out of range 2 .. 2^W-1");
        end
    endgenerate

    localparam logic [W-1:0] TMO     = W'(TIMEOUT);
    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    logic level;
    logic rise;
    logic fall;

    sync_edge_detect u_sync (
        .clk    (clk),
        .reset  (reset),
        .sig_in (sig_in),
        .level  (level),
        .rise   (rise),
        .fall   (fall)
    );

    meas_state_t state_reg;
    meas_state_t state_next;
    logic [W-1:0] cnt_reg;
    logic [W-1:0] hi_tmp_reg;
    logic [W-1:0] lo_acc_reg;
    logic [W-1:0] high_time_reg;
    logic         valid_reg;
    logic         timeout_reg;
    logic         capture_hi;
    logic         measure;
    logic         stall;
    logic [W:0]   sum_full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (rise || fall) begin
            cnt_reg <= {{(W-1){1'b0}}, 1'b1};
        end else if (cnt_reg != CNT_MAX) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // An edge always wins over a coincident cnt == TIMEOUT; the stall test
    // only applies while the line still sits at the level the state expects.
    always_comb begin
        state_next = state_reg;
        capture_hi = 1'b0;
        measure    = 1'b0;
        stall      = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (rise) begin
                    state_next = S_HIGH;
                end
            end
            S_HIGH: begin
                if (fall) begin
                    capture_hi = 1'b1;
                    state_next = S_LOW;
                end else if (level && cnt_reg == TMO) begin
                    stall      = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_LOW: begin
                if (rise) begin
                    measure    = 1'b1;
                    state_next = S_HIGH;
                end else if (!level && cnt_reg == TMO) begin
                    stall      = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_tmp_reg    <= '0;
            lo_acc_reg    <= '0;
            high_time_reg <= '0;
            valid_reg     <= 1'b0;
            timeout_reg   <= 1'b0;
        end else begin
            valid_reg <= measure;
            if (capture_hi) begin
                hi_tmp_reg <= cnt_reg;
            end
            if (measure) begin
                high_time_reg <= hi_tmp_reg;
                lo_acc_reg    <= cnt_reg;
                timeout_reg   <= 1'b0;
            end else if (stall) begin
                timeout_reg   <= 1'b1;
            end
        end
    end

    // Period is the saturated sum of the two held half-period registers, so it
    // updates on exactly the same edge as high_time.
    assign sum_full  = {1'b0, high_time_reg} + {1'b0, lo_acc_reg};
    assign period    = sum_full[W] ? CNT_MAX : sum_full[W-1:0];
    assign high_time = high_time_reg;
    assign valid     = valid_reg;
    assign timeout   = timeout_reg;

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: a W=16/TIMEOUT=20 instance and a
// W=4/TIMEOUT=15 instance share clock, reset and the measured signal.
module tb_clk_period_meter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sig_in = 1'b0;
    logic [15:0] period;
    logic [15:0] high_time;
    logic        valid;
    logic        timeout;
    logic [3:0]  period_s;
    logic [3:0]  high_s;
    logic        valid_s;
    logic        timeout_s;

    always #5 clk = ~clk;

    clk_period_meter #(.W(16), .TIMEOUT(20)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .sig_in    (sig_in),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .timeout   (timeout)
    );

    clk_period_meter #(.W(4), .TIMEOUT(15)) u_small (
        .clk       (clk),
        .reset     (reset),
        .sig_in    (sig_in),
        .period    (period_s),
        .high_time (high_s),
        .valid     (valid_s),
        .timeout   (timeout_s)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int c0;
    int nv, ns, it_total, to_iter, to_seen, tos_seen;
    int vp[16], vh[16], vt[16], vc[16];
    int sp[16], sh[16];

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        nv = 0; ns = 0; it_total = 0; to_iter = -1; to_seen = 0; tos_seen = 0;
        c0 = cyc;
        for (int i = 0; i < 16; i++) begin
            vp[i] = 0; vh[i] = 0; vt[i] = 0; vc[i] = 0; sp[i] = 0; sh[i] = 0;
        end
    endtask

    // Hold sig_in at lvl for n cycles, logging every valid pulse of both DUTs.
    task automatic run(input logic lvl, input int n);
        sig_in = lvl;
        repeat (n) begin
            @(negedge clk);
            it_total++;
            if (valid) begin
                if (nv < 16) begin
                    vp[nv] = int'(period); vh[nv] = int'(high_time);
                    vt[nv] = int'(timeout); vc[nv] = cyc;
                end
                nv++;
            end
            if (valid_s) begin
                if (ns < 16) begin
                    sp[ns] = int'(period_s); sh[ns] = int'(high_s);
                end
                ns++;
            end
            if (timeout && to_iter < 0) to_iter = it_total;
            if (timeout) to_seen = 1;
            if (timeout_s) tos_seen = 1;
            @(posedge clk); #1;
        end
    endtask

    task automatic waves(input int hi, input int lo, input int n);
        for (int k = 0; k < n; k++) begin
            run(1'b1, hi);
            run(1'b0, lo);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sig_in = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        run(1'b0, 6);
    endtask

    initial begin
        #1 reset = 1'b1;
        @(posedge clk); #1;
        check("rst_period", period, 0);
        check("rst_high", high_time, 0);
        check("rst_valid", valid, 0);
        check("rst_timeout", timeout, 0);
        check("rst_small_period", period_s, 0);
        reset = 1'b0;
        run(1'b0, 6);

        // 4 high / 4 low
        clear_log();
        waves(4, 4, 4);
        check("sq44_count", nv, 3);
        check("sq44_first_latency", vc[0] - c0, 11);
        for (int i = 0; i < 3; i++) begin
            check("sq44_period", vp[i], 8);
            check("sq44_high", vh[i], 4);
            check("sq44_timeout", vt[i], 0);
        end
        check("sq44_gap1", vc[1] - vc[0], 8);
        check("sq44_gap2", vc[2] - vc[1], 8);
        check("sq44_no_timeout", to_seen, 0);

        // 3 high / 5 low, then 10 high / 2 low
        do_reset();
        clear_log();
        waves(3, 5, 3);
        waves(10, 2, 3);
        check("duty_count", nv, 5);
        for (int i = 0; i < 3; i++) begin
            check("duty35_period", vp[i], 8);
            check("duty35_high", vh[i], 3);
        end
        for (int i = 3; i < 5; i++) begin
            check("duty102_period", vp[i], 12);
            check("duty102_high", vh[i], 10);
        end

        // stall while low
        do_reset();
        waves(4, 4, 1);
        run(1'b1, 4);
        clear_log();
        run(1'b0, 40);
        check("stall_rise_iter", to_iter, 24);
        check("stall_no_valid", nv, 0);
        check("stall_level", timeout, 1);
        clear_log();
        waves(4, 4, 1);
        check("stall_persists", timeout, 1);
        check("stall_restart_no_valid", nv, 0);
        clear_log();
        waves(4, 4, 1);
        check("restart_count", nv, 1);
        check("restart_period", vp[0], 8);
        check("restart_high", vh[0], 4);
        check("restart_timeout_at_valid", vt[0], 0);
        check("restart_timeout_after", timeout, 0);

        // half period exactly TIMEOUT
        do_reset();
        clear_log();
        waves(20, 20, 1);
        run(1'b1, 20);
        run(1'b0, 4);
        check("edge_tmo_count", nv, 1);
        check("edge_tmo_period", vp[0], 40);
        check("edge_tmo_high", vh[0], 20);
        check("edge_tmo_no_timeout", to_seen, 0);

        // asynchronous reset during a high phase
        clear_log();
        run(1'b1, 2);
        #2 reset = 1'b1;
        #1;
        check("async_period", period, 0);
        check("async_high", high_time, 0);
        check("async_valid", valid, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        clear_log();
        run(1'b1, 4);
        run(1'b0, 4);
        waves(4, 4, 2);
        check("after_rst_count", nv, 1);
        check("after_rst_period", vp[0], 8);
        check("after_rst_high", vh[0], 4);

        // W=4 saturation: 7 high / 10 low
        do_reset();
        clear_log();
        waves(7, 10, 3);
        check("sat_count", ns, 2);
        for (int i = 0; i < 2; i++) begin
            check("sat_period", sp[i], 15);
            check("sat_high", sh[i], 7);
        end
        check("sat_no_timeout", tos_seen, 0);
        check("wide_period", vp[0], 17);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_period_meter.md
Name: clk_period_meter

Overview:
- Receive-side companion to the team's divided-clock generators. Measures a slow square wave, such as a divider output or an external test signal, in units of the fast system clock.
- The input is asynchronous to `clk`. The block synchronises it, detects edges, and reports period and high time once per complete cycle.
- Also flags a stalled or stuck input with a timeout.
- Used on the DE0-Nano designs for self-checking divider outputs and for driving displays with measured frequencies.

Parameters:
- W, 16, width of the counter and of the measurement outputs.
- TIMEOUT, 50000, number of cycles without an edge after which the input is declared stalled. Legal range 2 .. 2^W-1; checked by elaboration assertion.

Ports:
- clk  input  1  system clock; all state on posedge.
- reset  input  1  asynchronous, active-high reset.
- sig_in  input  1  measured signal; asynchronous to clk.
- period  output  W  clk cycles between the last two rising edges.
- high_time  output  W  clk cycles from a rising edge to the following falling edge.
- valid  output  1  one-cycle pulse; period and high_time have just been updated.
- timeout  output  1  level; high after a stall, cleared by the next valid.

Behaviour:
- Reset: asynchronous, active-high, one clock `clk`. While reset is high, all outputs and internal state are 0 and the state is S_IDLE.
- Synchroniser: two flops, sync1 then sync2, both reset to 0.
  - prev register holds sync2 delayed by one cycle.
  - rise = sync2 & !prev; fall = !sync2 & prev.
  - An edge on sig_in is seen as rise/fall 2-3 cycles later. The delay is identical for both edges, so measurements are exact.
- Counter cnt (W bits):
  - Set to 1 in any cycle with rise or fall; otherwise increments.
  - Saturates at 2^W-1; never wraps.
  - On an edge, cnt therefore equals the cycles since the previous edge.
- Held low-time register lo_acc (W bits): stores the low time captured on fall-to-rise.
- State machine, states S_IDLE, S_HIGH, S_LOW (enum in package):
  - S_IDLE:
    - rise -> S_HIGH.
    - fall is ignored; the partial first period is discarded.
    - No timeout checking in S_IDLE.
  - S_HIGH:
    - fall -> capture hi_tmp <= cnt, then -> S_LOW.
    - cnt == TIMEOUT with no edge -> S_IDLE, timeout <= 1.
  - S_LOW:
    - rise -> period <= hi_tmp + cnt (width W, saturating at 2^W-1); high_time <= hi_tmp; valid <= 1; timeout <= 0; -> S_HIGH.
    - cnt == TIMEOUT with no edge -> S_IDLE, timeout <= 1.
- Outputs:
  - period, high_time and timeout are registered and hold until the next update.
  - valid is high exactly one cycle: the cycle after the rise is detected.
  - First valid appears only after rise, fall, rise have all been seen in sequence.
- Simultaneous events: an edge in the same cycle as cnt == TIMEOUT takes priority; no timeout is raised.
- timeout persists through S_IDLE and the next S_HIGH/S_LOW. It is cleared only by valid or by reset.
- Reset mid-measurement: any partial result is discarded, and the outputs return to 0 asynchronously.
- Half-period limit: a half period longer than TIMEOUT always produces a timeout, never a measurement.

Decomposition:
- Package clk_meas_pkg holds:
  - typedef enum logic [1:0] meas_state_t {S_IDLE, S_HIGH, S_LOW};
  - default constants for W and TIMEOUT.
- One sub-module, sync_edge_detect:
  - Two-flop synchroniser plus prev flop.
  - Outputs level, rise and fall.
  - Same clk/reset convention; reusable by other receivers.
- Counter, FSM and output registers stay in clk_period_meter.

Test Plan:
- Reset, then square wave 4 cycles high / 4 low (a divider with terminal count 3) -> first valid after the second detected rise; period=8, high_time=4; then valid every 8 cycles, with timeout=0 throughout.
- Duty-cycle wave, 3 high / 5 low -> period=8, high_time=3 on every valid. Switch to 10 high / 2 low mid-stream -> the first full new cycle reports period=12, high_time=10; no spurious values in between.
- TIMEOUT=20: establish valid measurements, then hold sig_in low -> timeout rises exactly 20 cycles after the last detected fall, and valid stays 0. Restart the toggling -> timeout clears on the first new valid, after a full rise/fall/rise sequence.
- Edge arriving in the same cycle cnt reaches TIMEOUT (half period = TIMEOUT) -> no timeout; measurement reported normally.
- Assert reset asynchronously mid-high-phase -> outputs 0 immediately (before the next posedge). After release, the sig_in high at that moment is ignored until a fresh rise.
- W=4, TIMEOUT=15, wave 7 high / 10 low -> period saturates to 15, high_time=7; no wrap.
